// File: rtl/rs_age.sv
// Age-ordered ALU reservation station: buffers issued ops, captures CDB results, dispatches the oldest ready op.
// Latency: an op ready at issue edge N is in the alu_* slot after edge N+1; a wakeup at edge N makes the op eligible for edge N+1.
// Backpressure: the alu_* slot holds while alu_en && !alu_ready; issue while full is dropped; rs_nxt_full flags the edge that fills the station.
module rs_age #(
    parameter int DEPTH     = 16,
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32,
    parameter int N_CDB     = 2,
    parameter int OPCODE_W  = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           rollback,
    output logic                           rs_nxt_full,
    output logic [$clog2(DEPTH):0]         rs_count,
    input  logic                           issue,
    input  logic [ROB_POS_W-1:0]           issue_rob_pos,
    input  logic [OPCODE_W-1:0]            issue_opcode,
    input  logic [2:0]                     issue_funct3,
    input  logic                           issue_funct7,
    input  logic [DATA_W-1:0]              issue_rs1_val,
    input  logic [DATA_W-1:0]              issue_rs2_val,
    input  logic [ROB_POS_W:0]             issue_rs1_rob_id,
    input  logic [ROB_POS_W:0]             issue_rs2_rob_id,
    input  logic [DATA_W-1:0]              issue_imm,
    input  logic [DATA_W-1:0]              issue_pc,
    output logic                           alu_en,
    input  logic                           alu_ready,
    output logic [OPCODE_W-1:0]            alu_opcode,
    output logic [2:0]                     alu_funct3,
    output logic                           alu_funct7,
    output logic [DATA_W-1:0]              alu_val1,
    output logic [DATA_W-1:0]              alu_val2,
    output logic [DATA_W-1:0]              alu_imm,
    output logic [DATA_W-1:0]              alu_pc,
    output logic [ROB_POS_W-1:0]           alu_rob_pos,
    input  logic [N_CDB-1:0]               cdb_en,
    input  logic [N_CDB*ROB_POS_W-1:0]     cdb_rob_pos,
    input  logic [N_CDB*DATA_W-1:0]        cdb_val
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = ROB_POS_W + 1;
    localparam int OPN_W = TAG_W + DATA_W;

    // Operand-independent part of an entry.
    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } meta_t;

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  older_q [DEPTH];   // older_q[i][j]: entry i issued before entry j
    meta_t             meta_q  [DEPTH];
    logic [TAG_W-1:0]  tag1_q  [DEPTH];
    logic [TAG_W-1:0]  tag2_q  [DEPTH];
    logic [DATA_W-1:0] val1_q  [DEPTH];
    logic [DATA_W-1:0] val2_q  [DEPTH];

    logic [OPN_W-1:0]  wake1 [DEPTH];
    logic [OPN_W-1:0]  wake2 [DEPTH];
    logic [OPN_W-1:0]  iss1, iss2;
    logic [DEPTH-1:0]  ready, sel_ok;
    logic              free_found, sel_found;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic              advance, slot_open, load, issue_acc;
    logic [CNT_W-1:0]  nxt_count;

    // Resolve one operand against the broadcast ports; lowest matching port wins.
    function automatic logic [OPN_W-1:0] snoop(
        input logic [TAG_W-1:0]           tag,
        input logic [DATA_W-1:0]          val,
        input logic [N_CDB-1:0]           en,
        input logic [N_CDB*ROB_POS_W-1:0] pos,
        input logic [N_CDB*DATA_W-1:0]    cv
    );
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] v;
        logic              hit;
        t   = tag;
        v   = val;
        hit = 1'b0;
        for (int k = 0; k < N_CDB; k++) begin
            if (!hit && tag[TAG_W-1] && en[k] &&
                pos[k*ROB_POS_W +: ROB_POS_W] == tag[ROB_POS_W-1:0]) begin
                hit = 1'b1;
                t   = '0;
                v   = cv[k*DATA_W +: DATA_W];
            end
        end
        return {t, v};
    endfunction

    // Operand capture for stored entries (wakeup) and for the incoming op (same-cycle bypass).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = snoop(tag1_q[i], val1_q[i], cdb_en, cdb_rob_pos, cdb_val);
            wake2[i] = snoop(tag2_q[i], val2_q[i], cdb_en, cdb_rob_pos, cdb_val);
        end
        iss1 = snoop(issue_rs1_rob_id, issue_rs1_val, cdb_en, cdb_rob_pos, cdb_val);
        iss2 = snoop(issue_rs2_rob_id, issue_rs2_val, cdb_en, cdb_rob_pos, cdb_val);
    end

    // Lowest-index free entry, from registered busy only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Ready entries, and those with no older ready entry (at most one survives).
    always_comb begin
        ready  = '0;
        sel_ok = '0;
        for (int i = 0; i < DEPTH; i++)
            ready[i] = busy_q[i] && !tag1_q[i][TAG_W-1] && !tag2_q[i][TAG_W-1];
        for (int i = 0; i < DEPTH; i++) begin
            sel_ok[i] = ready[i];
            for (int j = 0; j < DEPTH; j++)
                if (ready[j] && older_q[j][i]) sel_ok[i] = 1'b0;
        end
    end

    // Encode the selected entry.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_ok[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Per-cycle control: what actually happens at the coming edge.
    always_comb begin
        advance   = rdy && !rollback;
        slot_open = !alu_en || alu_ready;
        load      = advance && slot_open && sel_found;
        issue_acc = advance && issue && free_found;
        if (!rdy)
            nxt_count = rs_count;
        else if (rollback)
            nxt_count = '0;
        else
            nxt_count = rs_count + CNT_W'(issue_acc) - CNT_W'(load);
        rs_nxt_full = (nxt_count == CNT_W'(DEPTH));
    end

    // Entry storage: wakeup, dispatch release, issue write and age update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
                meta_q[i]  <= '0;
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                val1_q[i]  <= '0;
                val2_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                busy_q <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    {tag1_q[i], val1_q[i]} <= wake1[i];
                    {tag2_q[i], val2_q[i]} <= wake2[i];
                end
                if (load)
                    busy_q[sel_idx] <= 1'b0;
                if (issue_acc) begin
                    busy_q[free_idx] <= 1'b1;
                    meta_q[free_idx] <= '{opcode: issue_opcode, funct3: issue_funct3,
                                          funct7: issue_funct7, imm: issue_imm,
                                          pc: issue_pc, rob_pos: issue_rob_pos};
                    {tag1_q[free_idx], val1_q[free_idx]} <= iss1;
                    {tag2_q[free_idx], val2_q[free_idx]} <= iss2;
                    // Everything already resident is older than the newcomer.
                    for (int j = 0; j < DEPTH; j++)
                        older_q[j][free_idx] <= busy_q[j];
                    older_q[free_idx] <= '0;
                end
            end
        end
    end

    // Output slot: load when empty or being drained, hold under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
            if (rollback) begin
                alu_en <= 1'b0;
            end else if (slot_open) begin
                alu_en <= sel_found;
                if (sel_found) begin
                    alu_opcode  <= meta_q[sel_idx].opcode;
                    alu_funct3  <= meta_q[sel_idx].funct3;
                    alu_funct7  <= meta_q[sel_idx].funct7;
                    alu_imm     <= meta_q[sel_idx].imm;
                    alu_pc      <= meta_q[sel_idx].pc;
                    alu_rob_pos <= meta_q[sel_idx].rob_pos;
                    alu_val1    <= val1_q[sel_idx];
                    alu_val2    <= val2_q[sel_idx];
                end
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rs_count <= '0;
        else
            rs_count <= nxt_count;
    end
endmodule

// File: tb/tb_rs_age.sv
module tb_rs_age;
    localparam int DEPTH = 16;
    localparam int RW    = 4;
    localparam int DW    = 32;
    localparam int NC    = 2;
    localparam int OW    = 7;
    localparam int TW    = RW + 1;
    localparam int CW    = 5;

    logic clk, rst, rdy, rollback, rs_nxt_full;
    logic [CW-1:0] rs_count;
    logic issue, issue_funct7;
    logic [RW-1:0] issue_rob_pos;
    logic [OW-1:0] issue_opcode;
    logic [2:0] issue_funct3;
    logic [DW-1:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic [TW-1:0] issue_rs1_rob_id, issue_rs2_rob_id;
    logic alu_en, alu_ready, alu_funct7;
    logic [OW-1:0] alu_opcode;
    logic [2:0] alu_funct3;
    logic [DW-1:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [RW-1:0] alu_rob_pos;
    logic [NC-1:0] cdb_en;
    logic [NC*RW-1:0] cdb_rob_pos;
    logic [NC*DW-1:0] cdb_val;

    rs_age #(.DEPTH(DEPTH), .ROB_POS_W(RW), .DATA_W(DW), .N_CDB(NC), .OPCODE_W(OW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .rs_nxt_full(rs_nxt_full), .rs_count(rs_count),
        .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
        .issue_rs1_rob_id(issue_rs1_rob_id), .issue_rs2_rob_id(issue_rs2_rob_id),
        .issue_imm(issue_imm), .issue_pc(issue_pc),
        .alu_en(alu_en), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_val1(alu_val1),
        .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos),
        .cdb_en(cdb_en), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] rob; logic [OW-1:0] op; logic [2:0] f3; logic f7;
        logic [DW-1:0] v1; logic [DW-1:0] v2; logic [DW-1:0] imm; logic [DW-1:0] pc;
    } pay_t;
    typedef struct packed { logic en; logic [CW-1:0] cnt; logic full; pay_t pay; } obs_t;
    typedef struct { pay_t pay; bit p1; bit p2; logic [RW-1:0] t1; logic [RW-1:0] t2; } ent_t;

    // Reference model: a queue in issue order, so "oldest" is simply the first ready element.
    ent_t mq[$];
    bit   m_en;
    pay_t m_pay;
    bit   exp_full;
    logic obs_full;
    int   checks = 0;
    int   failures = 0;

    function automatic obs_t observe();
        return {alu_en, rs_count, obs_full, alu_rob_pos, alu_opcode, alu_funct3, alu_funct7,
                alu_val1, alu_val2, alu_imm, alu_pc};
    endfunction

    function automatic obs_t expected();
        return {m_en, CW'(mq.size()), exp_full, m_pay};
    endfunction

    function automatic void cdb_hit(input logic [RW-1:0] pos, output bit hit, output logic [DW-1:0] v);
        hit = 0;
        v = '0;
        for (int k = 0; k < NC; k++)
            if (!hit && cdb_en[k] && cdb_rob_pos[k*RW +: RW] == pos) begin
                hit = 1;
                v = cdb_val[k*DW +: DW];
            end
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_en = 0;
        m_pay = '0;
    endfunction

    task automatic idle_inputs();
        rdy = 1; rollback = 0; issue = 0; alu_ready = 1;
        issue_rob_pos = '0; issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 0;
        issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_rob_id = '0; issue_rs2_rob_id = '0;
        issue_imm = '0; issue_pc = '0;
        cdb_en = '0; cdb_rob_pos = '0; cdb_val = '0;
    endtask

    task automatic set_issue(input logic [RW-1:0] rob, input logic [TW-1:0] t1, input logic [DW-1:0] v1,
                             input logic [TW-1:0] t2, input logic [DW-1:0] v2);
        issue = 1; issue_rob_pos = rob;
        issue_rs1_rob_id = t1; issue_rs1_val = v1;
        issue_rs2_rob_id = t2; issue_rs2_val = v2;
        issue_opcode = OW'($urandom); issue_funct3 = 3'($urandom); issue_funct7 = 1'($urandom);
        issue_imm = $urandom; issue_pc = $urandom;
    endtask

    task automatic set_cdb(input int port, input logic [RW-1:0] pos, input logic [DW-1:0] v);
        cdb_en[port] = 1'b1;
        cdb_rob_pos[port*RW +: RW] = pos;
        cdb_val[port*DW +: DW] = v;
    endtask

    // Advance one clock: predict rs_nxt_full before the edge, then update the model at the edge.
    task automatic tick();
        int f, nsz;
        bit open, iss_ok, h;
        logic [DW-1:0] v;
        ent_t e;
        @(negedge clk);
        f = -1;
        for (int k = 0; k < mq.size(); k++)
            if (f < 0 && !mq[k].p1 && !mq[k].p2) f = k;
        open = !m_en || alu_ready;
        iss_ok = issue && (mq.size() < DEPTH);
        if (!rdy) nsz = mq.size();
        else if (rollback) nsz = 0;
        else nsz = mq.size() + int'(iss_ok) - int'(open && f >= 0);
        exp_full = (nsz == DEPTH);
        obs_full = rs_nxt_full;
        @(posedge clk);
        if (rdy && rollback) begin
            mq.delete();
            m_en = 0;
        end else if (rdy) begin
            if (open) begin
                m_en = (f >= 0);
                if (f >= 0) m_pay = mq[f].pay;
            end
            for (int k = 0; k < mq.size(); k++) begin
                e = mq[k];
                if (e.p1) begin cdb_hit(e.t1, h, v); if (h) begin e.p1 = 0; e.pay.v1 = v; end end
                if (e.p2) begin cdb_hit(e.t2, h, v); if (h) begin e.p2 = 0; e.pay.v2 = v; end end
                mq[k] = e;
            end
            if (open && f >= 0) mq.delete(f);
            if (iss_ok) begin
                e.pay = {issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
                         issue_rs1_val, issue_rs2_val, issue_imm, issue_pc};
                e.p1 = issue_rs1_rob_id[TW-1]; e.t1 = issue_rs1_rob_id[RW-1:0];
                e.p2 = issue_rs2_rob_id[TW-1]; e.t2 = issue_rs2_rob_id[RW-1:0];
                if (e.p1) begin cdb_hit(e.t1, h, v); if (h) begin e.p1 = 0; e.pay.v1 = v; end end
                if (e.p2) begin cdb_hit(e.t2, h, v); if (h) begin e.p2 = 0; e.pay.v2 = v; end end
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic restart();
        idle_inputs();
        @(negedge clk);
        rst = 0;
        model_clear();
        #2 rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        model_clear();
        #3;
        checks++;
        if ({alu_en, rs_count, rs_nxt_full} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got en=%0b cnt=%0d full=%0b want all 0", alu_en, rs_count, rs_nxt_full);
        end
        checks++;
        if ({alu_rob_pos, alu_val1, alu_val2, alu_imm, alu_pc, alu_opcode} !== '0) begin
            failures++;
            $display("FAIL reset_payload got rob=%0d v1=%h v2=%h want zeros", alu_rob_pos, alu_val1, alu_val2);
        end
        #4 rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        restart();
        set_issue(4'd3, '0, 32'd5, '0, 32'd7);
        for (int s = 0; s < 3; s++) begin
            tick();
            issue = 0;
            checks++;
            if (observe() !== expected()) begin
                failures++;
                $display("FAIL basic step=%0d got=%h want=%h", s, observe(), expected());
            end
            if (s == 1) begin
                checks++;
                if ({alu_en, alu_val1, alu_val2, alu_rob_pos} !== {1'b1, 32'd5, 32'd7, 4'd3}) begin
                    failures++;
                    $display("FAIL basic_dispatch got en=%0b v1=%0d v2=%0d rob=%0d want 1/5/7/3", alu_en, alu_val1, alu_val2, alu_rob_pos);
                end
            end
        end
        checks++;
        if ({alu_en, rs_count} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL basic_drain got en=%0b cnt=%0d want 0/0", alu_en, rs_count);
        end
    endtask

    task automatic test_wakeup();
        restart();
        set_issue(4'd1, 5'h12, 32'h0, 5'h00, 32'h22);
        tick();
        issue = 0;
        set_cdb(1, 4'd2, 32'hAB);
        for (int s = 0; s < 3; s++) begin
            tick();
            cdb_en = '0;
            checks++;
            if (observe() !== expected()) begin
                failures++;
                $display("FAIL wakeup step=%0d got=%h want=%h", s, observe(), expected());
            end
            if (s == 0 && alu_en !== 1'b0) begin
                failures++;
                $display("FAIL wakeup_early got en=%0b want 0", alu_en);
            end
            if (s == 1) begin
                checks++;
                if ({alu_en, alu_val1, alu_rob_pos} !== {1'b1, 32'hAB, 4'd1}) begin
                    failures++;
                    $display("FAIL wakeup_dispatch got en=%0b v1=%h rob=%0d want 1/ab/1", alu_en, alu_val1, alu_rob_pos);
                end
            end
        end
    endtask

    task automatic test_bypass();
        restart();
        set_issue(4'd4, 5'h00, 32'h11, 5'h15, 32'h0);
        set_cdb(0, 4'd5, 32'd9);
        tick();
        issue = 0;
        cdb_en = '0;
        tick();
        checks++;
        if (observe() !== expected()) begin
            failures++;
            $display("FAIL bypass got=%h want=%h", observe(), expected());
        end
        checks++;
        if ({alu_en, alu_val2, alu_rob_pos} !== {1'b1, 32'd9, 4'd4}) begin
            failures++;
            $display("FAIL bypass_dispatch got en=%0b v2=%0d rob=%0d want 1/9/4", alu_en, alu_val2, alu_rob_pos);
        end
    endtask

    task automatic test_age_order();
        logic [RW-1:0] got[$];
        logic [RW-1:0] want[3];
        want[0] = 4'd7; want[1] = 4'd8; want[2] = 4'd9;
        restart();
        alu_ready = 0;
        // A ready op parks in the output slot so the later ops land in non-monotonic slots.
        set_issue(4'd10, '0, 32'h1, '0, 32'h2); tick();
        set_issue(4'd7, 5'h10, 32'h0, '0, 32'h3); tick();
        set_issue(4'd8, 5'h10, 32'h0, '0, 32'h4); tick();
        set_issue(4'd9, '0, 32'h5, 5'h10, 32'h0); tick();
        issue = 0;
        alu_ready = 1;
        set_cdb(0, 4'd0, 32'h55);
        tick();
        cdb_en = '0;
        for (int s = 0; s < 6; s++) begin
            tick();
            checks++;
            if (observe() !== expected()) begin
                failures++;
                $display("FAIL age step=%0d got=%h want=%h", s, observe(), expected());
            end
            if (alu_en) got.push_back(alu_rob_pos);
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL age_count got %0d dispatches want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    failures++;
                    $display("FAIL age_order idx=%0d got rob=%0d want %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] got[$];
        restart();
        alu_ready = 0;
        for (int n = 0; n <= DEPTH; n++) begin
            set_issue(RW'(n), '0, $urandom, '0, $urandom);
            tick();
            checks++;
            if (observe() !== expected()) begin
                failures++;
                $display("FAIL bp_fill n=%0d got=%h want=%h", n, observe(), expected());
            end
            if (n >= 1) begin
                checks++;
                if ({obs_full, alu_en, alu_rob_pos} !== {(n == DEPTH), 1'b1, 4'd0}) begin
                    failures++;
                    $display("FAIL bp_hold n=%0d got full=%0b en=%0b rob=%0d want full=%0b en=1 rob=0", n, obs_full, alu_en, alu_rob_pos, (n == DEPTH));
                end
            end
        end
        issue = 0;
        got.push_back(alu_rob_pos);
        alu_ready = 1;
        for (int s = 0; s < DEPTH + 3; s++) begin
            tick();
            checks++;
            if (observe() !== expected()) begin
                failures++;
                $display("FAIL bp_drain step=%0d got=%h want=%h", s, observe(), expected());
            end
            if (alu_en) got.push_back(alu_rob_pos);
        end
        checks++;
        if (got.size() != DEPTH + 1) begin
            failures++;
            $display("FAIL bp_lost got %0d dispatches want %0d", got.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i <= DEPTH; i++)
                if (got[i] !== RW'(i)) begin
                    failures++;
                    $display("FAIL bp_order idx=%0d got rob=%0d want %0d", i, got[i], RW'(i));
                end
        end
    endtask

    task automatic test_rollback();
        restart();
        alu_ready = 0;
        for (int n = 0; n < 5; n++) begin
            set_issue(RW'(n), 5'h1F, 32'h0, '0, 32'h1);
            tick();
        end
        checks++;
        if (rs_count !== 5'd5) begin
            failures++;
            $display("FAIL rb_fill got cnt=%0d want 5", rs_count);
        end
        set_issue(4'd6, '0, 32'h1, '0, 32'h2);
        rollback = 1;
        tick();
        rollback = 0;
        issue = 0;
        checks++;
        if ({alu_en, rs_count} !== {1'b0, 5'd0} || observe() !== expected()) begin
            failures++;
            $display("FAIL rb_flush got en=%0b cnt=%0d want 0/0", alu_en, rs_count);
        end
        alu_ready = 1;
        set_cdb(0, 4'd15, 32'h77);
        for (int s = 0; s < 3; s++) begin
            tick();
            cdb_en = '0;
            checks++;
            if (alu_en !== 1'b0 || observe() !== expected()) begin
                failures++;
                $display("FAIL rb_quiet step=%0d got=%h want=%h", s, observe(), expected());
            end
        end
    endtask

    task automatic test_reset_midstream();
        restart();
        alu_ready = 0;
        for (int n = 0; n < 3; n++) begin
            set_issue(RW'(n + 1), '0, $urandom, '0, $urandom);
            tick();
        end
        issue = 0;
        #2 rst = 0;
        model_clear();
        #1;
        checks++;
        if ({alu_en, rs_count, rs_nxt_full, alu_rob_pos} !== '0) begin
            failures++;
            $display("FAIL mid_reset got en=%0b cnt=%0d full=%0b rob=%0d want zeros", alu_en, rs_count, rs_nxt_full, alu_rob_pos);
        end
        @(negedge clk);
        rst = 1;
        alu_ready = 1;
        for (int s = 0; s < 2; s++) begin
            tick();
            checks++;
            if (alu_en !== 1'b0 || observe() !== expected()) begin
                failures++;
                $display("FAIL mid_restart step=%0d got=%h want=%h", s, observe(), expected());
            end
        end
    endtask

    task automatic test_random();
        logic [TW-1:0] t1, t2;
        restart();
        for (int s = 0; s < 1500; s++) begin
            idle_inputs();
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 60) == 0);
            alu_ready = ($urandom_range(0, 9) < 6);
            if (mq.size() < DEPTH && $urandom_range(0, 9) < 6) begin
                t1 = $urandom_range(0, 9) < 4 ? {1'b1, 1'b0, 3'($urandom)} : {1'b0, 4'($urandom)};
                t2 = $urandom_range(0, 9) < 4 ? {1'b1, 1'b0, 3'($urandom)} : {1'b0, 4'($urandom)};
                set_issue(4'($urandom), t1, $urandom, t2, $urandom);
            end
            for (int k = 0; k < NC; k++)
                if ($urandom_range(0, 2) == 0) set_cdb(k, 4'($urandom_range(0, 7)), $urandom);
            tick();
            checks++;
            if (observe() !== expected()) begin
                failures++;
                $display("FAIL random step=%0d got=%h want=%h", s, observe(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_age_order();
        test_backpressure();
        test_rollback();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
